rv_mem_responder: RTL and testbench

RV_MEM_RESPONDER -- requirements
Module: rv_mem_responder

---
 rtl/rv_mem_responder.sv | 135 +++++++++++++
 tb/tb_rv_mem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_responder.sv
// Single-outstanding memory responder: word-addressed storage with byte-enable writes
// and a programmable wait between request acceptance and response.
module rv_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic        req_bad;
    logic        mem_we;
    logic        handshake;

    assign word_idx  = req_addr[AW+1:2];
    assign req_bad   = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= DEPTH_U);
    // req_ready_q is only ever 1 in IDLE, so it doubles as the state qualifier.
    assign handshake = req_valid && req_ready_q;

    // NOTE: every variable assigned here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (handshake) begin
                    req_ready_d = 1'b0;
                    rsp_err_d   = req_bad;
                    rsp_rdata_d = (req_bad || req_we) ? 32'h0 : mem[word_idx];
                    mem_we      = req_we && !req_bad;
                    if (LATENCY == 0) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // Return to IDLE with req_ready set, so a new request lands one edge later.
                if (rsp_valid_q && rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // NOTE: storage has no reset so it maps onto RAM and keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) begin
                    mem[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rv_mem_responder.sv
// Directed bench for rv_mem_responder: one instance with LATENCY=2, one with LATENCY=0,
// sharing stimulus; sel picks which instance is driven and observed.
module tb_rv_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;

    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;
    logic        req_valid_a, req_valid_b;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign req_valid_a = req_valid && !sel;
    assign req_valid_b = req_valid && sel;
    assign req_ready   = sel ? req_ready_b : req_ready_a;
    assign rsp_valid   = sel ? rsp_valid_b : rsp_valid_a;
    assign rsp_rdata   = sel ? rsp_rdata_b : rsp_rdata_a;
    assign rsp_err     = sel ? rsp_err_b   : rsp_err_a;

    rv_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid_a),
        .req_ready (req_ready_a),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid_a),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata_a),
        .rsp_err   (rsp_err_a)
    );

    rv_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid_b),
        .req_ready (req_ready_b),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid_b),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata_b),
        .rsp_err   (rsp_err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction: wait for ready, handshake, count edges to rsp_valid, check, complete.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int lat,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat + 1));
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int n;
        int accepts;
        int resps;
        reset     = 1'b1;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Basic write/read and byte-enable merge at LATENCY=2
        do_req("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 32'h0, 1'b0);
        do_req("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEADBEEF, 1'b0);
        do_req("wr10_be", 1'b1, 32'h10, 32'h00001234, 4'b0011, 2, 32'h0, 1'b0);
        do_req("rd10_be", 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEAD1234, 1'b0);
        do_req("wr10_be0", 1'b1, 32'h10, 32'h55555555, 4'b0000, 2, 32'h0, 1'b0);
        do_req("rd10_be0", 1'b0, 32'h10, 32'h0, 4'hF, 2, 32'hDEAD1234, 1'b0);

        // Error cases: misaligned and out-of-range, top word untouched
        do_req("wr_ffc", 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 2, 32'h0, 1'b0);
        do_req("rd_mis", 1'b0, 32'h13, 32'h0, 4'h0, 2, 32'h0, 1'b1);
        do_req("wr_oor", 1'b1, 32'h1000, 32'h12345678, 4'hF, 2, 32'h0, 1'b1);
        do_req("wr_mis", 1'b1, 32'hFFE, 32'h87654321, 4'hF, 2, 32'h0, 1'b1);
        do_req("rd_ffc", 1'b0, 32'hFFC, 32'h0, 4'h0, 2, 32'hCAFEF00D, 1'b0);

        // Back-pressure: hold rsp_ready low, poke a write that must be ignored
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_lat", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 2);
            req_we    = 1'b1;
            req_wdata = 32'h0;
            req_be    = 4'hF;
            @(posedge clk);
            #1;
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata", rsp_rdata, 32'hDEAD1234);
            check("stall_err", 32'(rsp_err), 32'd0);
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("stall_release", 32'(rsp_valid), 32'd0);
        check("stall_idle", 32'(req_ready), 32'd1);
        do_req("rd10_after_stall", 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEAD1234, 1'b0);

        // LATENCY=0 instance: single-edge latency and 2-cycle throughput
        sel = 1'b1;
        do_req("l0_wr4", 1'b1, 32'h4, 32'h11223344, 4'hF, 0, 32'h0, 1'b0);
        do_req("l0_rd4", 1'b0, 32'h4, 32'h0, 4'h0, 0, 32'h11223344, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h4;
        rsp_ready = 1'b1;
        accepts   = 0;
        resps     = 0;
        for (int i = 0; i < 8; i++) begin
            if (req_ready) accepts++;
            if (rsp_valid) resps++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("l0_accepts", 32'(accepts), 32'd4);
        check("l0_resps", 32'(resps), 32'd4);
        check("l0_b2b_idle", 32'(req_ready), 32'd1);
        rsp_ready = 1'b0;

        // Reset during WAIT after a committed write
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hA5A55A5A;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check("rstw_ready", 32'(req_ready), 32'd0);
        check("rstw_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rstw_ready_after", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("rstw_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_req("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 2, 32'hA5A55A5A, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
